// File: rtl/ntt_product_sequencer.sv
// ntt_product_sequencer: stage controller for one NTT-based large-integer product.
// Runs FWD_A -> FWD_B -> PW -> INV -> DONE. It drives each sub-engine through an
// ap_ctrl_hs handshake and presents ap_ctrl_chain upward.
// NUM_FWD=1 selects squaring, which skips FWD_B.
// Optional feature macro: NTT_SEQ_PERF_EN adds a per-stage cycle counter
// (perf_cycles / perf_valid).
//
// state | meaning
// IDLE  | waiting for ap_start
// FWD_A | forward NTT of operand A (fwd_sel=0)
// FWD_B | forward NTT of operand B (fwd_sel=1)
// PW    | pointwise modular multiply
// INV   | inverse NTT
// DONE  | ap_done held until ap_continue
module ntt_product_sequencer #(
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_continue,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic             ap_done,
    output logic             fwd_start,
    input  logic             fwd_ready,
    input  logic             fwd_done,
    output logic             fwd_sel,
    output logic             pw_start,
    input  logic             pw_ready,
    input  logic             pw_done,
    output logic             inv_start,
    input  logic             inv_ready,
    input  logic             inv_done,
    output logic [2:0]       stage
`ifdef NTT_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_cycles,
    output logic             perf_valid
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FWD_A = 3'd1,
        S_FWD_B = 3'd2,
        S_PW    = 3'd3,
        S_INV   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   fwd_start_q, fwd_start_d;
    logic   pw_start_q, pw_start_d;
    logic   inv_start_q, inv_start_d;
    logic   fwd_sel_q, fwd_sel_d;
    logic   ap_ready_q, ap_ready_d;
    logic   ap_done_q, ap_done_d;
    logic   fwd_cmpl, pw_cmpl, inv_cmpl;
    logic   enter;

    // Stage completion: while start is still high, done only counts together with
    // ready. A lone done during issue is an engine protocol error and is ignored.
    always_comb begin
        fwd_cmpl = fwd_start_q ? (fwd_ready & fwd_done) : fwd_done;
        pw_cmpl  = pw_start_q  ? (pw_ready  & pw_done)  : pw_done;
        inv_cmpl = inv_start_q ? (inv_ready & inv_done) : inv_done;
    end

    // Next-state and registered-output computation.
    // Starts are raised only on stage entry, so each engine sees one start per stage.
    always_comb begin
        state_d     = state_q;
        fwd_start_d = fwd_start_q;
        pw_start_d  = pw_start_q;
        inv_start_d = inv_start_q;
        fwd_sel_d   = fwd_sel_q;
        ap_ready_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ap_start) state_d = S_FWD_A;
            end
            S_FWD_A: begin
                if (fwd_start_q && fwd_ready) fwd_start_d = 1'b0;
                if (fwd_cmpl) state_d = (NUM_FWD == 1) ? S_PW : S_FWD_B;
            end
            S_FWD_B: begin
                if (fwd_start_q && fwd_ready) fwd_start_d = 1'b0;
                if (fwd_cmpl) state_d = S_PW;
            end
            S_PW: begin
                if (pw_start_q && pw_ready) pw_start_d = 1'b0;
                if (pw_cmpl) state_d = S_INV;
            end
            S_INV: begin
                if (inv_start_q && inv_ready) inv_start_d = 1'b0;
                if (inv_cmpl) state_d = S_DONE;
            end
            S_DONE: begin
                if (ap_continue) state_d = ap_start ? S_FWD_A : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        enter = (state_d != state_q);
        if (enter) begin
            fwd_start_d = (state_d == S_FWD_A) || (state_d == S_FWD_B);
            pw_start_d  = (state_d == S_PW);
            inv_start_d = (state_d == S_INV);
            fwd_sel_d   = (state_d == S_FWD_B);
            ap_ready_d  = (state_d == S_PW);
        end
        ap_done_d = (state_d == S_DONE);
    end

    // State and output registers; reset drops all starts immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fwd_start_q <= 1'b0;
            pw_start_q  <= 1'b0;
            inv_start_q <= 1'b0;
            fwd_sel_q   <= 1'b0;
            ap_ready_q  <= 1'b0;
            ap_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fwd_start_q <= fwd_start_d;
            pw_start_q  <= pw_start_d;
            inv_start_q <= inv_start_d;
            fwd_sel_q   <= fwd_sel_d;
            ap_ready_q  <= ap_ready_d;
            ap_done_q   <= ap_done_d;
        end
    end

    assign ap_idle   = (state_q == S_IDLE);
    assign ap_ready  = ap_ready_q;
    assign ap_done   = ap_done_q;
    assign fwd_start = fwd_start_q;
    assign pw_start  = pw_start_q;
    assign inv_start = inv_start_q;
    assign fwd_sel   = fwd_sel_q;
    assign stage     = state_q;

`ifdef NTT_SEQ_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] perf_cycles_q, perf_cycles_d;
    logic             perf_valid_q, perf_valid_d;
    logic             busy;

    // Per-stage counter. The value latched at exit includes the exit cycle itself.
    always_comb begin
        busy          = (state_q == S_FWD_A) || (state_q == S_FWD_B) ||
                        (state_q == S_PW)    || (state_q == S_INV);
        cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_d         = cnt_q;
        perf_cycles_d = perf_cycles_q;
        perf_valid_d  = 1'b0;
        if (busy) cnt_d = cnt_inc;
        if (busy && enter) begin
            perf_valid_d  = 1'b1;
            perf_cycles_d = cnt_inc;
        end
        if (enter) cnt_d = '0;
    end

    // Counter and reported-value registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            perf_cycles_q <= '0;
            perf_valid_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            perf_cycles_q <= perf_cycles_d;
            perf_valid_q  <= perf_valid_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_valid  = perf_valid_q;
`endif

endmodule

// File: tb/tb_ntt_product_sequencer.sv
// Testbench for ntt_product_sequencer: one NUM_FWD=2 instance and one squaring instance share stimulus.
module tb_ntt_product_sequencer;

    logic clock, reset, ap_start, ap_continue;
    logic fwd_ready, fwd_done, pw_ready, pw_done, inv_ready, inv_done;

    logic       ap_idle, ap_ready, ap_done, fwd_start, fwd_sel, pw_start, inv_start;
    logic [2:0] stage;
    logic       ap_idle_s, ap_ready_s, ap_done_s, fwd_start_s, fwd_sel_s, pw_start_s, inv_start_s;
    logic [2:0] stage_s;
`ifdef NTT_SEQ_PERF_EN
    logic [31:0] perf_cycles, perf_cycles_s;
    logic        perf_valid, perf_valid_s;
`endif

    int total = 0;
    int bad   = 0;
    int exp_stage[$];

    ntt_product_sequencer #(.NUM_FWD(2), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
        .fwd_start(fwd_start), .fwd_ready(fwd_ready), .fwd_done(fwd_done), .fwd_sel(fwd_sel),
        .pw_start(pw_start), .pw_ready(pw_ready), .pw_done(pw_done),
        .inv_start(inv_start), .inv_ready(inv_ready), .inv_done(inv_done),
        .stage(stage)
`ifdef NTT_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_valid(perf_valid)
`endif
    );

    ntt_product_sequencer #(.NUM_FWD(1), .CNT_W(32)) dut_sq (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_idle(ap_idle_s), .ap_ready(ap_ready_s), .ap_done(ap_done_s),
        .fwd_start(fwd_start_s), .fwd_ready(fwd_ready), .fwd_done(fwd_done), .fwd_sel(fwd_sel_s),
        .pw_start(pw_start_s), .pw_ready(pw_ready), .pw_done(pw_done),
        .inv_start(inv_start_s), .inv_ready(inv_ready), .inv_done(inv_done),
        .stage(stage_s)
`ifdef NTT_SEQ_PERF_EN
        , .perf_cycles(perf_cycles_s), .perf_valid(perf_valid_s)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_eng(input logic v);
        fwd_ready = v; fwd_done = v;
        pw_ready  = v; pw_done  = v;
        inv_ready = v; inv_done = v;
    endtask

    task automatic do_reset;
        reset = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
        set_eng(1'b0);
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && !ap_idle; i++) tick;
        total++;
        if (ap_idle !== 1'b1) begin
            bad++; $display("FAIL %s idle timeout: ap_idle=%b want 1", name, ap_idle);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
        set_eng(1'b0);
        tick; tick;
        total++;
        if ({ap_idle, ap_ready, ap_done, fwd_start, pw_start, inv_start, fwd_sel} !== 7'b1000000) begin
            bad++; $display("FAIL reset_outputs: got %b want 1000000",
                {ap_idle, ap_ready, ap_done, fwd_start, pw_start, inv_start, fwd_sel});
        end
        total++;
        if (stage !== 3'd0) begin bad++; $display("FAIL reset_stage: got %0d want 0", stage); end
`ifdef NTT_SEQ_PERF_EN
        total++;
        if (perf_cycles !== 32'd0 || perf_valid !== 1'b0) begin
            bad++; $display("FAIL reset_perf: got %0d/%b want 0/0", perf_cycles, perf_valid);
        end
`endif
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int e;
        do_reset;
        set_eng(1'b1);
        ap_continue = 1'b1;
        ap_start = 1'b1;
        exp_stage.push_back(1); exp_stage.push_back(2); exp_stage.push_back(3);
        exp_stage.push_back(4); exp_stage.push_back(5);
        tick;
        ap_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            e = exp_stage.pop_front();
            total++;
            if (stage !== 3'(e)) begin bad++; $display("FAIL basic_stage c%0d: got %0d want %0d", c, stage, e); end
            total++;
            if (ap_ready !== (c == 3)) begin bad++; $display("FAIL basic_ap_ready c%0d: got %b", c, ap_ready); end
            total++;
            if (fwd_sel !== (c == 2)) begin bad++; $display("FAIL basic_fwd_sel c%0d: got %b", c, fwd_sel); end
            total++;
            if (ap_done !== (c == 5)) begin bad++; $display("FAIL basic_ap_done c%0d: got %b", c, ap_done); end
            total++;
            if (ap_idle !== 1'b0) begin bad++; $display("FAIL basic_idle c%0d: got %b want 0", c, ap_idle); end
            if (c < 5) tick;
        end
        tick;
        total++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
            bad++; $display("FAIL basic_return_idle: idle=%b done=%b want 1/0", ap_idle, ap_done);
        end
    endtask

    task automatic test_fwd_delay;
        int highs = 0;
        do_reset;
        ap_start = 1'b1;
        tick;
        ap_start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            fwd_ready = (c == 5);
            fwd_done  = (c == 16);
            if (fwd_start) highs++;
            total++;
            if (stage !== 3'd1) begin bad++; $display("FAIL delay_stage c%0d: got %0d want 1", c, stage); end
            total++;
            if (fwd_start !== (c <= 5)) begin bad++; $display("FAIL delay_fwd_start c%0d: got %b want %b", c, fwd_start, c <= 5); end
            tick;
        end
        total++;
        if (highs != 5) begin bad++; $display("FAIL delay_start_count: got %0d want 5", highs); end
        total++;
        if (stage !== 3'd2 || fwd_sel !== 1'b1 || fwd_start !== 1'b1) begin
            bad++; $display("FAIL delay_enter_fwd_b: stage=%0d sel=%b start=%b want 2/1/1", stage, fwd_sel, fwd_start);
        end
`ifdef NTT_SEQ_PERF_EN
        total++;
        if (perf_valid !== 1'b1 || perf_cycles !== 32'd16) begin
            bad++; $display("FAIL delay_perf: valid=%b cycles=%0d want 1/16", perf_valid, perf_cycles);
        end
`endif
        set_eng(1'b1);
        ap_continue = 1'b1;
        wait_idle("delay");
    endtask

    task automatic test_continue_hold;
        do_reset;
        set_eng(1'b1);
        ap_start = 1'b1;
        tick;
        ap_start = 1'b0;
        tick; tick; tick; tick;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (ap_done !== 1'b1 || stage !== 3'd5 || ap_idle !== 1'b0) begin
                bad++; $display("FAIL hold_done k%0d: done=%b stage=%0d idle=%b want 1/5/0", k, ap_done, stage, ap_idle);
            end
            if (k == 7) begin ap_continue = 1'b1; ap_start = 1'b1; end
            tick;
        end
        ap_start = 1'b0;
        total++;
        if (stage !== 3'd1 || ap_done !== 1'b0 || ap_idle !== 1'b0 || fwd_start !== 1'b1) begin
            bad++; $display("FAIL back_to_back: stage=%0d done=%b idle=%b start=%b want 1/0/0/1", stage, ap_done, ap_idle, fwd_start);
        end
        wait_idle("back_to_back");
    endtask

    task automatic test_squaring;
        int e;
        int starts = 0;
        do_reset;
        set_eng(1'b1);
        ap_continue = 1'b1;
        ap_start = 1'b1;
        exp_stage.push_back(1); exp_stage.push_back(3); exp_stage.push_back(4); exp_stage.push_back(5);
        tick;
        ap_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            e = exp_stage.pop_front();
            if (fwd_start_s) starts++;
            total++;
            if (stage_s !== 3'(e)) begin bad++; $display("FAIL sq_stage c%0d: got %0d want %0d", c, stage_s, e); end
            total++;
            if (fwd_sel_s !== 1'b0) begin bad++; $display("FAIL sq_fwd_sel c%0d: got %b want 0", c, fwd_sel_s); end
            total++;
            if (ap_ready_s !== (c == 2)) begin bad++; $display("FAIL sq_ap_ready c%0d: got %b", c, ap_ready_s); end
            total++;
            if (ap_done_s !== (c == 4)) begin bad++; $display("FAIL sq_ap_done c%0d: got %b", c, ap_done_s); end
            tick;
        end
        total++;
        if (starts != 1) begin bad++; $display("FAIL sq_start_count: got %0d want 1", starts); end
        total++;
        if (ap_idle_s !== 1'b1) begin bad++; $display("FAIL sq_idle: got %b want 1", ap_idle_s); end
        wait_idle("squaring");
    endtask

    task automatic test_async_reset;
        do_reset;
        fwd_ready = 1'b1; fwd_done = 1'b1;
        ap_start = 1'b1;
        tick;
        ap_start = 1'b0;
        tick; tick; tick;
        total++;
        if (stage !== 3'd3 || pw_start !== 1'b1) begin
            bad++; $display("FAIL arst_pre: stage=%0d pw_start=%b want 3/1", stage, pw_start);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (pw_start !== 1'b0 || stage !== 3'd0 || ap_idle !== 1'b1 || ap_ready !== 1'b0) begin
            bad++; $display("FAIL arst_immediate: pw_start=%b stage=%0d idle=%b want 0/0/1", pw_start, stage, ap_idle);
        end
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_pw_protocol;
        do_reset;
        fwd_ready = 1'b1; fwd_done = 1'b1;
        ap_start = 1'b1;
        tick;
        ap_start = 1'b0;
        tick; tick;
        pw_done = 1'b1;
        tick;
        pw_done = 1'b0;
        total++;
        if (stage !== 3'd3 || pw_start !== 1'b1) begin
            bad++; $display("FAIL pw_done_ignored: stage=%0d pw_start=%b want 3/1", stage, pw_start);
        end
        tick;
        total++;
        if (stage !== 3'd3) begin bad++; $display("FAIL pw_still_issue: stage=%0d want 3", stage); end
        pw_ready = 1'b1; pw_done = 1'b1;
        tick;
        total++;
        if (stage !== 3'd4 || pw_start !== 1'b0 || inv_start !== 1'b1) begin
            bad++; $display("FAIL pw_same_cycle: stage=%0d pw_start=%b inv_start=%b want 4/0/1", stage, pw_start, inv_start);
        end
        set_eng(1'b1);
        ap_continue = 1'b1;
        wait_idle("pw_protocol");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_fwd_delay;
        test_continue_hold;
        test_squaring;
        test_async_reset;
        test_pw_protocol;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_product_sequencer.md
Name: ntt_product_sequencer

Overview:
- Top-level stage controller for the NTT-based large-integer product.
- Runs one full product as: forward NTT on operand A, forward NTT on operand B, pointwise modular multiply, inverse NTT.
- Talks to each sub-engine through its ap_ctrl_hs handshake (std2rev forward engine, pointwise engine, rev2std inverse engine).
- Presents an ap_ctrl_chain interface upward, so the existing nodf_module monitors can observe every start/ready/done edge.

Parameters:
- NUM_FWD, 2, number of forward transforms per product. 2 = normal A*B. 1 = squaring: FWD_B is skipped and fwd_sel stays 0.
- CNT_W, 32, width of the per-stage cycle counter (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ap_start  in  1  request one product
- ap_continue  in  1  upstream acknowledge of ap_done
- ap_idle  out  1  high only in IDLE
- ap_ready  out  1  1-cycle pulse: inputs consumed, operand buffers reusable
- ap_done  out  1  product complete; held until ap_continue
- fwd_start  out  1  forward-engine ap_start
- fwd_ready  in  1  forward-engine ap_ready
- fwd_done  in  1  forward-engine ap_done
- fwd_sel  out  1  operand buffer select for the forward engine (0=A, 1=B); stable for the whole stage
- pw_start / pw_ready / pw_done  out/in/in  1 each  pointwise-engine handshake
- inv_start / inv_ready / inv_done  out/in/in  1 each  inverse-engine handshake
- stage  out  3  current state encoding (IDLE=0, FWD_A=1, FWD_B=2, PW=3, INV=4, DONE=5)

Behaviour:
- Reset values: state IDLE; ap_idle=1; ap_ready=0; ap_done=0; all *_start=0; fwd_sel=0; stage=0.
- Reset mid-operation: immediate return to IDLE and all *_start low. Sub-engines are not flushed; the system reset covers them.
- Each stage has two phases:
  - Issue: x_start held high from the first cycle in the stage until x_ready is sampled 1.
  - Wait: x_start low; wait for x_done=1.
- x_ready and x_done both 1 in the same cycle: stage completes that cycle.
- x_done seen during the issue phase without x_ready: ignored. This is a sub-engine protocol error.
- x_start is not re-asserted after acceptance. Each engine gets exactly one start per stage.
- Transitions (each taken on the cycle its condition is sampled true; the next state is entered on the following edge):
  - IDLE -> FWD_A when ap_start=1.
  - FWD_A -> FWD_B on fwd done (NUM_FWD=2).
  - FWD_A -> PW on fwd done (NUM_FWD=1).
  - FWD_B -> PW on fwd done.
  - PW -> INV on pw done.
  - INV -> DONE on inv done.
  - DONE -> IDLE when ap_continue=1.
  - DONE -> FWD_A directly if ap_continue=1 and ap_start=1 in the same cycle (back-to-back, no idle bubble).
- fwd_sel: 0 in FWD_A, 1 in FWD_B, 0 elsewhere; registered, and changes only on state entry.
- ap_ready: registered 1-cycle pulse on the cycle after the last forward transform completes (entry into PW). Raw operands are no longer read after that point.
- ap_done: registered; 1 throughout DONE, including the cycle ap_continue is sampled; 0 on the next cycle.
- ap_idle: combinational decode of state==IDLE.
- ap_start while not in IDLE/DONE: ignored and not queued.
- Latency: 1 cycle of entry per stage plus engine latencies. Minimum with single-cycle engines (ready=done=1 on the start cycle), NUM_FWD=2: ap_start sampled at cycle 0 -> ap_done high at cycle 5.

Optional Feature:
- Macro: NTT_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_cycles [CNT_W-1:0] and perf_valid [1].
  - One counter clears on stage entry and increments every cycle in FWD_A/FWD_B/PW/INV, saturating at all-ones.
  - On each stage exit, perf_valid pulses 1 cycle and perf_cycles holds that stage's count; the value is held until the next exit.
  - Both outputs reset to 0.
- Undefined: ports and counter absent; all other behaviour identical.

Test Plan:
- Reset then single-cycle engines, NUM_FWD=2, ap_start pulse at cycle 0 -> stage sequence 1,2,3,4,5; ap_ready pulse at cycle 3; ap_done=1 at cycle 5; fwd_sel=1 only in FWD_B.
- fwd_ready delayed 4 cycles, fwd_done 10 cycles later -> fwd_start high for exactly 5 cycles and then low; no second start; FWD_A lasts 16 cycles (with NTT_SEQ_PERF_EN: perf_cycles=16, perf_valid pulse at exit).
- ap_continue held 0 for 7 cycles in DONE -> ap_done stays 1 for 8 cycles; ap_continue=1 with ap_start=1 -> next cycle stage=1, ap_idle never asserted.
- NUM_FWD=1 -> stage goes 1,3,4,5; fwd_start asserted once; fwd_sel constant 0.
- Async reset asserted mid-PW with pw_start high -> pw_start=0 and stage=0 immediately, before the next clock edge; ap_idle=1.
- pw_done pulsed during the PW issue phase without pw_ready -> ignored, stage stays 3; later pw_ready=1 and pw_done=1 in the same cycle -> INV entered on the next edge.
